rpn_sequencer: RTL and testbench

- Sequences one RPN token at a time from the token decoder through the operand stack and the ALU.
- Number tokens are pushed onto the stack.
- Operator tokens pop their operands, start the ALU, wait for its result, push the result back and present it as the answer.
- Detects underflow, overflow, ALU fault, ALU timeout and bad arity; on any error, flushes the stack and reports one error pulse.

---
 rtl/rpn_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// RPN token sequencer. It takes one token at a time and drives the operand stack
// and the ALU, reporting each answer or a single error pulse.
module rpn_sequencer #(
  parameter int W           = 16,
  parameter int OP_W        = 4,
  parameter int DEPTH_W     = 4,
  parameter int STACK_DEPTH = 15,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic               tok_is_op,
  input  logic [1:0]         tok_arg_cnt,
  input  logic [W-1:0]       tok_data,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_clear,
  output logic [W-1:0]       stk_wdata,
  input  logic [W-1:0]       stk_rdata,
  input  logic [DEPTH_W-1:0] stk_depth,
  output logic               alu_start,
  output logic [OP_W-1:0]    alu_op,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  input  logic               alu_done,
  input  logic [W-1:0]       alu_result,
  input  logic               alu_err,
  output logic               ans_ready,
  output logic [W-1:0]       ans_data,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, PUSH_NUM, POP_B, POP_A, EXEC, WAIT, PUSH_RES, ERR
  } state_t;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_UNDER    = 3'd1,
    E_OVER     = 3'd2,
    E_ALU      = 3'd3,
    E_TIMEOUT  = 3'd4,
    E_ARITY    = 3'd5
  } err_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // NOTE: every register below is assigned with <= so all state updates on the
  // same edge read pre-edge values; a blocking = here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tok_ready <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_clear <= 1'b0;
      stk_wdata <= '0;
      alu_start <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      ans_ready <= 1'b0;
      ans_data  <= '0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      wait_cnt  <= '0;
    end else begin
      // Strobes default low so each one lasts exactly the cycle after it is set.
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_clear <= 1'b0;
      alu_start <= 1'b0;
      ans_ready <= 1'b0;
      err       <= 1'b0;
      tok_ready <= 1'b0;

      case (state)
        IDLE: begin
          tok_ready <= 1'b1;
          if (tok_valid && tok_ready) begin
            tok_ready <= 1'b0;
            if (!tok_is_op) begin
              if (stk_depth == DEPTH_W'(STACK_DEPTH)) begin
                state     <= ERR;
                err       <= 1'b1;
                stk_clear <= 1'b1;
                err_code  <= E_OVER;
              end else begin
                state     <= PUSH_NUM;
                stk_push  <= 1'b1;
                stk_wdata <= tok_data;
              end
            end else begin
              alu_op <= tok_data[OP_W-1:0];
              if (tok_arg_cnt == 2'd0 || tok_arg_cnt == 2'd3) begin
                state     <= ERR;
                err       <= 1'b1;
                stk_clear <= 1'b1;
                err_code  <= E_ARITY;
              end else if (stk_depth < DEPTH_W'(tok_arg_cnt)) begin
                // Underflow is caught before any pop, so the stack is untouched
                // until the flush.
                state     <= ERR;
                err       <= 1'b1;
                stk_clear <= 1'b1;
                err_code  <= E_UNDER;
              end else if (tok_arg_cnt == 2'd2) begin
                state   <= POP_B;
                stk_pop <= 1'b1;
              end else begin
                state   <= POP_A;
                stk_pop <= 1'b1;
                alu_b   <= '0;
              end
            end
          end
        end

        PUSH_NUM: begin
          state     <= IDLE;
          tok_ready <= 1'b1;
        end

        // The top of stack read here is the entry being popped this same cycle.
        POP_B: begin
          alu_b   <= stk_rdata;
          state   <= POP_A;
          stk_pop <= 1'b1;
        end

        POP_A: begin
          alu_a     <= stk_rdata;
          state     <= EXEC;
          alu_start <= 1'b1;
        end

        EXEC: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt != CNT_W'(TIMEOUT))
            wait_cnt <= wait_cnt + CNT_W'(1);
          // A done arriving on the final allowed cycle takes priority over timeout.
          if (alu_done) begin
            if (alu_err) begin
              state     <= ERR;
              err       <= 1'b1;
              stk_clear <= 1'b1;
              err_code  <= E_ALU;
            end else begin
              state     <= PUSH_RES;
              stk_push  <= 1'b1;
              stk_wdata <= alu_result;
              ans_ready <= 1'b1;
              ans_data  <= alu_result;
            end
          end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
            state     <= ERR;
            err       <= 1'b1;
            stk_clear <= 1'b1;
            err_code  <= E_TIMEOUT;
          end
        end

        PUSH_RES: begin
          state     <= IDLE;
          tok_ready <= 1'b1;
        end

        ERR: begin
          state     <= IDLE;
          tok_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer. It runs a stack and ALU environment and predicts every
// token's outcome from a queue-based model of the RPN rules.
module tb_rpn_sequencer;
  localparam int W = 16, OP_W = 4, DEPTH_W = 4, STACK_DEPTH = 15, TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tok_valid = 1'b0, tok_is_op = 1'b0;
  logic [1:0]         tok_arg_cnt = '0;
  logic [W-1:0]       tok_data = '0;
  logic               tok_ready;
  logic               stk_push, stk_pop, stk_clear;
  logic [W-1:0]       stk_wdata, stk_rdata;
  logic [DEPTH_W-1:0] stk_depth;
  logic               alu_start, alu_done, alu_err;
  logic [OP_W-1:0]    alu_op;
  logic [W-1:0]       alu_a, alu_b, alu_result;
  logic               ans_ready, err;
  logic [W-1:0]       ans_data;
  logic [2:0]         err_code;

  always #5 clk = ~clk;

  rpn_sequencer #(.W(W), .OP_W(OP_W), .DEPTH_W(DEPTH_W), .STACK_DEPTH(STACK_DEPTH),
                  .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_arg_cnt(tok_arg_cnt), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_clear(stk_clear),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_depth(stk_depth),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .ans_ready(ans_ready), .ans_data(ans_data), .err(err), .err_code(err_code)
  );

  // Operand stack environment; it does not reset, so an abandoned op leaves it as is.
  logic [W-1:0] stk_mem [STACK_DEPTH+1];
  int sp = 0;
  always @(posedge clk) begin
    if (stk_clear) sp <= 0;
    else if (stk_push) begin
      if (sp <= STACK_DEPTH) stk_mem[sp] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_depth = DEPTH_W'(sp);
  assign stk_rdata = (sp > 0 && sp <= STACK_DEPTH + 1) ? stk_mem[sp-1] : '0;

  function automatic logic [W-1:0] alu_fn(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      default: return a ^ {b[7:0], b[15:8]};
    endcase
  endfunction

  // ALU environment: done arrives alu_lat cycles after the alu_start cycle (0 = never).
  int           alu_lat = 1;
  bit           alu_fault = 1'b0;
  bit           force_done = 1'b0;
  int           alu_cnt = -1;
  logic [W-1:0] cap_a, cap_b;
  logic [OP_W-1:0] cap_op;
  initial begin alu_done = 1'b0; alu_err = 1'b0; alu_result = '0; end
  always @(negedge clk) begin
    alu_done = 1'b0;
    alu_err  = 1'b0;
    if (force_done) begin
      alu_done   = 1'b1;
      alu_result = 16'hdead;
    end
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_done   = 1'b1;
        alu_err    = alu_fault;
        alu_result = alu_fn(cap_op, cap_a, cap_b);
        alu_cnt    = -1;
      end
    end
    if (alu_start) begin
      cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
      alu_cnt = (alu_lat > 0) ? alu_lat : -1;
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  logic [W-1:0] mdl[$];
  logic [W-1:0] last_ans = '0;
  logic [2:0]   last_code = '0;

  // Offer one token, observe the whole transaction, and compare it against the model.
  task automatic do_token(input bit is_op, input logic [1:0] ar, input logic [W-1:0] data,
                          input int lat, input bit fault);
    int exp_code = 0, exp_evt = 1, exp_pops = 0, exec_cyc;
    bit exp_ans = 1'b0;
    logic [W-1:0] ea = '0, eb = '0, er = '0;
    int n_push = 0, n_pop = 0, n_clr = 0, n_start = 0, n_ans = 0, n_err = 0;
    int push_cyc = -1, ans_cyc = -1, err_cyc = -1, ready_cyc = -1, k = 0, n = 0;
    logic [W-1:0] push_val = '0, got_ans = '0, got_a = '0, got_b = '0;
    logic [OP_W-1:0] got_op = '0;
    logic [2:0] got_code = '0;

    exec_cyc = (ar == 2'd2) ? 3 : 2;
    if (!is_op) begin
      if (mdl.size() == STACK_DEPTH) exp_code = 2;
      else er = data;
    end else if (ar == 2'd0 || ar == 2'd3) exp_code = 5;
    else if (mdl.size() < int'(ar)) exp_code = 1;
    else begin
      exp_pops = int'(ar);
      if (ar == 2'd2) eb = mdl.pop_back();
      ea = mdl.pop_back();
      er = alu_fn(data[OP_W-1:0], ea, eb);
      if (lat == 0 || lat > TIMEOUT) begin
        exp_code = 4;
        exp_evt  = exec_cyc + 1 + TIMEOUT;
      end else begin
        exp_evt = exec_cyc + 1 + lat;
        if (fault) exp_code = 3;
        else exp_ans = 1'b1;
      end
    end
    if (exp_code != 0) begin
      mdl.delete();
      last_code = 3'(exp_code);
    end else begin
      mdl.push_back(er);
      if (exp_ans) last_ans = er;
    end

    alu_lat = lat; alu_fault = fault;
    tok_is_op = is_op; tok_arg_cnt = ar; tok_data = data; tok_valid = 1'b1;
    while (!tok_ready && n < 200) begin @(negedge clk); n++; end
    check("accept_ready", tok_ready, 1);
    @(posedge clk);
    while (ready_cyc < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) tok_valid = 1'b0;
      if (stk_push)  begin n_push++; push_cyc = k; push_val = stk_wdata; end
      if (stk_pop)   n_pop++;
      if (stk_clear) n_clr++;
      if (alu_start) begin n_start++; got_a = alu_a; got_b = alu_b; got_op = alu_op; end
      if (ans_ready) begin n_ans++; ans_cyc = k; got_ans = ans_data; end
      if (err)       begin n_err++; err_cyc = k; got_code = err_code; end
      if (tok_ready) ready_cyc = k;
    end

    check("ready_cycle", ready_cyc, exp_evt + 1);
    check("pops", n_pop, exp_pops);
    check("err_pulses", n_err, (exp_code != 0));
    check("clears", n_clr, (exp_code != 0));
    check("answers", n_ans, exp_ans);
    if (exp_code != 0) begin
      check("err_code", got_code, exp_code);
      check("err_cycle", err_cyc, exp_evt);
      check("push_on_err", n_push, 0);
    end else begin
      check("pushes", n_push, 1);
      check("push_cycle", push_cyc, exp_evt);
      check("push_data", push_val, er);
    end
    if (exp_ans) begin
      check("ans_cycle", ans_cyc, exp_evt);
      check("ans_data", got_ans, er);
    end
    if (exp_pops > 0) begin
      check("alu_starts", n_start, 1);
      check("alu_a", got_a, ea);
      check("alu_b", got_b, eb);
      check("alu_op", got_op, data[OP_W-1:0]);
    end else check("no_start", n_start, 0);
    check("ans_hold", ans_data, last_ans);
    check("code_hold", err_code, last_code);
    check("depth", sp, mdl.size());
    if (mdl.size() > 0) check("top", stk_rdata, mdl[$]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, {stk_push, stk_pop, stk_clear, alu_start, ans_ready, err}, 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_tok_ready", tok_ready, 0);
    check("rst_regs", {alu_a, alu_b, alu_op, ans_data, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", tok_ready, 1);

    // Directed cases: 3 4 +, underflow, unary fault, timeout, done on timeout cycle.
    do_token(0, 0, 16'd3, 1, 0);
    do_token(0, 0, 16'd4, 1, 0);
    do_token(1, 2, 16'd0, 1, 0);
    do_token(1, 2, 16'd0, 1, 0);
    do_token(0, 0, 16'd11, 1, 0);
    do_token(0, 0, 16'd9, 1, 0);
    do_token(1, 1, 16'd5, 1, 1);
    do_token(0, 0, 16'd2, 1, 0);
    do_token(0, 0, 16'd3, 1, 0);
    do_token(1, 2, 16'd1, 0, 0);
    do_token(0, 0, 16'd2, 1, 0);
    do_token(0, 0, 16'd3, 1, 0);
    do_token(1, 2, 16'd0, TIMEOUT, 0);
    do_token(1, 3, 16'd0, 1, 0);
    do_token(1, 0, 16'd0, 1, 0);
    for (int i = 0; i < STACK_DEPTH + 1; i++) do_token(0, 0, 16'(100 + i), 1, 0);

    // Reset while waiting on the ALU: operation abandoned, late done ignored.
    do_token(0, 0, 16'd5, 1, 0);
    do_token(0, 0, 16'd6, 1, 0);
    alu_lat = 0;
    tok_is_op = 1'b1; tok_arg_cnt = 2'd2; tok_data = 16'd0; tok_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) tok_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    check("mid_rst_ready", tok_ready, 0);
    check("mid_rst_regs", {alu_a, alu_b, alu_op, ans_data, err_code}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 force_done = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tok_ready, 1);
    @(posedge clk);
    #1 force_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs("late_done");
    end
    void'(mdl.pop_back());
    void'(mdl.pop_back());
    last_ans = '0;
    last_code = '0;
    check("post_rst_depth", sp, mdl.size());

    // Randomized token stream.
    for (int i = 0; i < 300; i++) begin
      bit is_op;
      logic [1:0] ar;
      int lat, r;
      bit fault;
      is_op = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      ar = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
      r = $urandom_range(0, 19);
      fault = (r == 0);
      lat = (r == 1) ? (($urandom_range(0, 1) == 0) ? 0 : TIMEOUT + 1)
          : (r == 2) ? TIMEOUT : $urandom_range(1, 4);
      do_token(is_op, ar, 16'($urandom), lat, fault);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
